xperiph_bridge: RTL and testbench
=================================

// Module: xperiph_bridge
// PURPOSE
//  Parametrised peripheral bridge between the xctrl data bus and N_CH user peripheral
//  channels such as score display, VGA object table and PS2 paddles.
//  It replaces fixed per-peripheral select wires with a req/ack handshake.
//  Adds bus stall (busy), a per-access timeout and a sticky error flag for unmapped
//  or hung channels. Sits behind xaddr_decoder, which asserts sel for the bridge window.
// PARAMETERS
//  DATA_W     32  bus data width
//  N_CH       4   number of peripheral channels (1..16)
//  CH_ADDR_W  4   word-offset bits passed to each channel
//  TIMEOUT    15  max wait cycles for ch_ack before error (1..255)
//  CH_SEL_W   localparam = max(1,$clog2(N_CH)); channel index = addr[CH_SEL_W+CH_ADDR_W-1:CH_ADDR_W]
// PORTS
//  clk       in   1                  system clock
//  rst       in   1                  asynchronous, active-high reset
//  sel       in   1                  bus access to bridge window, held until busy low
//  we        in   1                  1=write, 0=read; valid with sel
//  addr      in   CH_SEL_W+CH_ADDR_W channel index + word offset
//  data_in   in   DATA_W             write data from controller
//  data_out  out  DATA_W             read data to controller
//  busy      out  1                  stall to controller
//  err       out  1                  sticky error (unmapped index or timeout)
//  err_clr   in   1                  clears err
//  ch_req    out  N_CH               one-hot request to addressed channel
//  ch_we     out  1                  latched we, shared by all channels
//  ch_addr   out  CH_ADDR_W          latched word offset
//  ch_wdata  out  DATA_W             latched write data
//  ch_ack    in   N_CH               per-channel completion, 1-cycle pulse or level
//  ch_rdata  in   N_CH*DATA_W        channel i read data at [i*DATA_W +: DATA_W], valid with ack
// BEHAVIOUR
//  Reset: state=IDLE; ch_req, ch_we, ch_addr, ch_wdata, data_out, err, wait counter all 0.
//  busy = sel in IDLE (combinational); 1 in ACCESS; 0 in RESP.
//  IDLE: on sel, latch we, addr, data_in, idx.
//   - idx<N_CH: ch_req[idx]<=1, cnt<=0, go ACCESS.
//   - idx>=N_CH: set err, data_out<=all-ones, no ch_req, go RESP.
//  ACCESS: ch_req[idx] held high; cnt++ each cycle.
//   - ch_ack[idx]=1: ch_req<=0; data_out<=ch_rdata[idx] if read, else unchanged; go RESP.
//   - else cnt==TIMEOUT-1: ch_req<=0, set err, data_out<=all-ones, go RESP.
//   - ch_ack on other channels is ignored. ack has priority over timeout in the same cycle.
//  RESP: exactly one cycle with busy=0; controller samples data_out; always go IDLE.
//   A new sel is not accepted in RESP.
//  Latency: sel at cycle 0 -> ch_req at cycle 1; ack at cycle k -> busy low and data_out
//   valid at cycle k+1. Minimum access is 3 cycles (sel, ack, RESP).
//  err: set wins over err_clr in the same cycle; otherwise err_clr clears it. Never self-clears.
//  data_out holds its last value between accesses.
//  ch_we, ch_addr, ch_wdata are stable for the whole ACCESS.
//  Reset asserted mid-access drops ch_req and all outputs immediately (async).
//  N_CH=1: CH_SEL_W=1; index 1 is unmapped.
// TESTING
//  1) Read ch2 offset 3, ack 2 cycles after req, rdata=0xCAFE0002 -> data_out=0xCAFE0002,
//     busy low for 1 cycle, err=0.
//  2) Write ch0 data 0x1 with ack in the same cycle as req -> ch_we=1, ch_wdata=0x1,
//     busy total 2 cycles, data_out unchanged.
//  3) Unmapped index (N_CH=3, idx=3) -> no ch_req, err=1, data_out=0xFFFFFFFF next cycle;
//     err_clr pulse -> err=0.
//  4) No ack, TIMEOUT=15 -> ch_req high exactly 15 cycles, then err=1, data_out=all-ones;
//     ack on ch1 during an access to ch0 is ignored.
//  5) Assert rst during ACCESS -> ch_req=0, busy=0 (sel low), state IDLE.
//     Next access completes normally.
//  6) Timeout on the final count coincides with err_clr and ack -> ack wins, err unchanged by
//     the access, err cleared.

Source files
------------

// File: rtl/xperiph_bridge.sv
// xperiph_bridge: req/ack bridge from the xctrl bus to N_CH peripheral channels,
// with bus stall, per-access timeout and a sticky error flag.
module xperiph_bridge #(
  parameter  int DATA_W    = 32,
  parameter  int N_CH      = 4,
  parameter  int CH_ADDR_W = 4,
  parameter  int TIMEOUT   = 15,
  localparam int CH_SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel,
  input  logic                          we,
  input  logic [CH_SEL_W+CH_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr,
  output logic [N_CH-1:0]               ch_req,
  output logic                          ch_we,
  output logic [CH_ADDR_W-1:0]          ch_addr,
  output logic [DATA_W-1:0]             ch_wdata,
  input  logic [N_CH-1:0]               ch_ack,
  input  logic [N_CH*DATA_W-1:0]        ch_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e                 state_q;
  logic [CH_SEL_W-1:0]    idx_q;
  logic [7:0]             cnt_q;
  logic [N_CH-1:0]        ch_req_q;
  logic                   ch_we_q;
  logic [CH_ADDR_W-1:0]   ch_addr_q;
  logic [DATA_W-1:0]      ch_wdata_q;
  logic [DATA_W-1:0]      data_out_q;
  logic                   err_q;

  logic [CH_SEL_W-1:0]    addr_idx;
  logic                   mapped;
  logic                   ack_sel;
  logic [DATA_W-1:0]      rdata_sel;
  logic [N_CH-1:0]        req_onehot;

  assign addr_idx = addr[CH_SEL_W+CH_ADDR_W-1:CH_ADDR_W];
  assign mapped   = int'(addr_idx) < N_CH;

  // Channel muxing: one-hot request for the new index, ack/rdata of the latched one.
  always_comb begin
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    req_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_onehot[i] = (addr_idx == CH_SEL_W'(i));
      if (idx_q == CH_SEL_W'(i)) begin
        ack_sel   = ch_ack[i];
        rdata_sel = ch_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bridge FSM: latch the access, run the channel handshake, time out hung channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      ch_req_q   <= '0;
      ch_we_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // A later set in the same cycle overrides this clear.
      if (err_clr) err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sel) begin
            ch_we_q    <= we;
            ch_addr_q  <= addr[CH_ADDR_W-1:0];
            ch_wdata_q <= data_in;
            idx_q      <= addr_idx;
            if (mapped) begin
              ch_req_q <= req_onehot;
              cnt_q    <= '0;
              state_q  <= S_ACCESS;
            end else begin
              err_q      <= 1'b1;
              data_out_q <= '1;
              state_q    <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 8'd1;
          if (ack_sel) begin
            ch_req_q <= '0;
            if (!ch_we_q) data_out_q <= rdata_sel;
            state_q  <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            ch_req_q   <= '0;
            err_q      <= 1'b1;
            data_out_q <= '1;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q == S_IDLE) ? sel : (state_q == S_ACCESS);
  assign data_out = data_out_q;
  assign err      = err_q;
  assign ch_req   = ch_req_q;
  assign ch_we    = ch_we_q;
  assign ch_addr  = ch_addr_q;
  assign ch_wdata = ch_wdata_q;

endmodule

// File: tb/tb_xperiph_bridge.sv
// tb_xperiph_bridge: directed table, hand sequences and random accesses
// against a transaction-level model of the bridge.
module tb_xperiph_bridge;

  localparam int DW  = 32;
  localparam int NCH = 3;
  localparam int AW  = 4;
  localparam int TO  = 15;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic              we;
  logic [SW+AW-1:0]  addr;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     data_out;
  logic              busy;
  logic              err;
  logic              err_clr;
  logic [NCH-1:0]    ch_req;
  logic              ch_we;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [NCH*DW-1:0] ch_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_data;
  bit            m_err;

  always #5 clk = ~clk;

  xperiph_bridge #(
    .DATA_W(DW), .N_CH(NCH), .CH_ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .busy(busy), .err(err),
    .err_clr(err_clr), .ch_req(ch_req), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack),
    .ch_rdata(ch_rdata)
  );

  typedef struct {
    bit          w;
    int          idx;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    bit          noise;
    bit          clr;
    int          ebusy;
    int          ereq;
    logic [31:0] edata;
    bit          eerr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation; updates the model's data/err state.
  function automatic void model(input vec_t v, output int eb, output int er,
                                output logic [31:0] ed, output bit ee);
    bit set;
    if (v.idx >= NCH) begin
      eb = 1; er = 0; set = 1'b1; m_data = '1;
    end else if (v.dly >= 0 && v.dly < TO) begin
      er = v.dly + 1; eb = v.dly + 2; set = 1'b0;
      if (!v.w) m_data = v.rd;
    end else begin
      er = TO; eb = TO + 1; set = 1'b1; m_data = '1;
    end
    m_err = set ? 1'b1 : (v.clr ? 1'b0 : m_err);
    ed = m_data;
    ee = m_err;
  endfunction

  // Drives one access from a negedge; returns at the negedge after RESP.
  task automatic run(input vec_t v, output int nbusy, output int nreq,
                     output logic [31:0] dout, output logic eo);
    bit             bad;
    int             other;
    int             cyc;
    logic [NCH-1:0] exp_oh;
    bad = 1'b0;
    cyc = 0;
    exp_oh = '0;
    if (v.idx < NCH) exp_oh[v.idx] = 1'b1;
    other = (v.idx + 1) % NCH;
    nbusy = 0;
    nreq = 0;
    sel = 1'b1;
    we = v.w;
    addr = {2'(v.idx), v.off};
    data_in = v.wd;
    err_clr = v.clr;
    while (cyc < 40) begin
      ch_ack = '0;
      ch_rdata = {$urandom, $urandom, $urandom};
      if (v.noise && v.idx < NCH) ch_ack[other] = 1'b1;
      if (ch_req != '0) begin
        nreq++;
        if (ch_req !== exp_oh || ch_we !== v.w || ch_addr !== v.off ||
            ch_wdata !== v.wd)
          bad = 1'b1;
        if (nreq - 1 == v.dly) begin
          ch_ack[v.idx] = 1'b1;
          ch_rdata[v.idx*DW +: DW] = v.rd;
        end
      end
      #1;
      if (!busy) break;
      nbusy++;
      cyc++;
      @(negedge clk);
    end
    chk("busy_bound", 32'(cyc >= 40), 32'd0);
    chk("req_lines", 32'(bad), 32'd0);
    chk("req_in_resp", 32'(ch_req), 32'd0);
    dout = data_out;
    eo = err;
    sel = 1'b0;
    err_clr = 1'b0;
    ch_ack = '0;
    @(negedge clk);
  endtask

  initial begin
    int          nb;
    int          nr;
    logic [31:0] d;
    logic        e;
    int          eb;
    int          er;
    logic [31:0] ed;
    bit          ee;
    vec_t        v;

    tbl[0] = '{0, 2, 4'd3,  32'h0,   32'hCAFE0002, 2,  0, 0, 4,  3,  32'hCAFE0002, 0};
    tbl[1] = '{1, 0, 4'd1,  32'h1,   32'hDEAD0000, 0,  0, 0, 2,  1,  32'hCAFE0002, 0};
    tbl[2] = '{0, 3, 4'd0,  32'h0,   32'h0,        0,  0, 0, 1,  0,  32'hFFFFFFFF, 1};
    tbl[3] = '{0, 1, 4'd2,  32'h0,   32'h00001111, 1,  0, 1, 3,  2,  32'h00001111, 0};
    tbl[4] = '{0, 0, 4'd0,  32'h0,   32'h00005555, 99, 1, 0, 16, 15, 32'hFFFFFFFF, 1};
    tbl[5] = '{0, 1, 4'd5,  32'h0,   32'h12345678, 14, 0, 1, 16, 15, 32'h12345678, 0};
    tbl[6] = '{1, 2, 4'd15, 32'hAA,  32'h0BAD0BAD, 5,  0, 0, 7,  6,  32'h12345678, 0};
    tbl[7] = '{0, 3, 4'd7,  32'h0,   32'h0,        0,  0, 1, 1,  0,  32'hFFFFFFFF, 1};

    rst = 1'b1;
    sel = 1'b0;
    we = 1'b0;
    addr = '0;
    data_in = '0;
    err_clr = 1'b0;
    ch_ack = '0;
    ch_rdata = '0;
    @(negedge clk);
    chk("rst_ch_req", 32'(ch_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ch_we", 32'(ch_we), 32'd0);
    chk("rst_ch_addr", 32'(ch_addr), 32'd0);
    chk("rst_ch_wdata", ch_wdata, 32'd0);
    rst = 1'b0;
    m_data = '0;
    m_err = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i], nb, nr, d, e);
      chk($sformatf("t%0d_busy_cycles", i), 32'(nb), 32'(tbl[i].ebusy));
      chk($sformatf("t%0d_req_cycles", i), 32'(nr), 32'(tbl[i].ereq));
      chk($sformatf("t%0d_data_out", i), d, tbl[i].edata);
      chk($sformatf("t%0d_err", i), 32'(e), 32'(tbl[i].eerr));
      m_data = tbl[i].edata;
      m_err = tbl[i].eerr;
    end

    // err_clr pulse on its own clears the sticky flag.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_pulse", 32'(err), 32'd0);
    chk("data_hold_idle", data_out, m_data);
    m_err = 1'b0;

    // Reset in the middle of an access.
    sel = 1'b1;
    we = 1'b0;
    addr = {2'd1, 4'd0};
    ch_ack = '0;
    repeat (3) @(negedge clk);
    chk("mid_req", 32'(ch_req), 32'h2);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(ch_req), 32'd0);
    sel = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_data = '0;
    m_err = 1'b0;
    @(negedge clk);
    v = '{0, 1, 4'd9, 32'h0, 32'h00000077, 3, 0, 0, 0, 0, 32'h0, 0};
    model(v, eb, er, ed, ee);
    run(v, nb, nr, d, e);
    chk("post_rst_busy", 32'(nb), 32'(eb));
    chk("post_rst_req", 32'(nr), 32'(er));
    chk("post_rst_data", d, ed);
    chk("post_rst_err", 32'(e), 32'(ee));

    for (int i = 0; i < 40; i++) begin
      v.w = 1'($urandom_range(0, 1));
      v.idx = int'($urandom_range(0, 3));
      v.off = 4'($urandom);
      v.wd = $urandom;
      v.rd = $urandom;
      v.dly = int'($urandom_range(0, 18));
      v.noise = 1'($urandom_range(0, 1));
      v.clr = ($urandom_range(0, 7) == 0);
      model(v, eb, er, ed, ee);
      run(v, nb, nr, d, e);
      chk($sformatf("r%0d_busy", i), 32'(nb), 32'(eb));
      chk($sformatf("r%0d_req", i), 32'(nr), 32'(er));
      chk($sformatf("r%0d_data", i), d, ed);
      chk($sformatf("r%0d_err", i), 32'(e), 32'(ee));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
